// File: rtl/spi_bus_arb.sv
// -----------------------------------------------------------------------------
// spi_bus_arb
//
// Shares one SPI master between the inertial-sensor client and the A2D client.
// Each client gets a one-deep request latch (pending flag + 16-bit command).
// Grants favour the inertial client, but after MAX_WAIT inertial grants made
// while the A2D is waiting, the next grant goes to the A2D. The granted command
// is launched on the master, SS_n/MISO are routed to the owning slave, and the
// received word is returned to that client with a one-cycle done pulse. A
// watchdog aborts a transfer the master never finishes.
//
// Ports
//   clk, RST_n                 clock, synchronous active-low reset
//   req_inrt/wdata_inrt        inertial request pulse and command word
//   done_inrt/rdata_inrt       inertial completion pulse and last read word
//   req_a2d/wdata_a2d          A2D request pulse and command word
//   done_a2d/rdata_a2d         A2D completion pulse and last read word
//   wrt/wrt_data               launch pulse and command word to the master
//   spi_done/spi_rd_data       master completion pulse and receive word
//   SS_n_mst                   master slave-select
//   SS_n_inrt/SS_n_a2d         per-slave selects
//   MISO_inrt/MISO_a2d/MISO    slave data in, muxed data to the master
//   owner                      current grant (0 inertial, 1 A2D)
//   busy                       a transaction is in progress
//   timeout_err                sticky watchdog-abort flag
// -----------------------------------------------------------------------------
module spi_bus_arb #(
    parameter int MAX_WAIT = 4,
    parameter int TIMEOUT  = 1048576
) (
    input  logic        clk,
    input  logic        RST_n,
    input  logic        req_inrt,
    input  logic [15:0] wdata_inrt,
    output logic        done_inrt,
    output logic [15:0] rdata_inrt,
    input  logic        req_a2d,
    input  logic [15:0] wdata_a2d,
    output logic        done_a2d,
    output logic [15:0] rdata_a2d,
    output logic        wrt,
    output logic [15:0] wrt_data,
    input  logic        spi_done,
    input  logic [15:0] spi_rd_data,
    input  logic        SS_n_mst,
    output logic        SS_n_inrt,
    output logic        SS_n_a2d,
    input  logic        MISO_inrt,
    input  logic        MISO_a2d,
    output logic        MISO,
    output logic        owner,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LAUNCH  = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] MAX_WAIT_C = SW'(MAX_WAIT);
    localparam logic [WW-1:0] TIMEOUT_C  = WW'(TIMEOUT);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_pend_inrt;
    logic          r_pend_a2d;
    logic [15:0]   r_hold_inrt;
    logic [15:0]   r_hold_a2d;
    logic          r_owner;
    logic [15:0]   r_wrt_data;
    logic [15:0]   r_rdata_inrt;
    logic [15:0]   r_rdata_a2d;
    logic [SW-1:0] r_starve_cnt;
    logic [WW-1:0] r_wd_cnt;
    logic          r_timeout_err;

    logic w_idle;
    logic w_grant;
    logic w_pick_a2d;
    logic w_grant_inrt;
    logic w_grant_a2d;
    logic w_accept_inrt;
    logic w_accept_a2d;
    logic w_wd_expired;

    // Grant decision, evaluated only while IDLE.
    assign w_idle       = (r_state == S_IDLE);
    assign w_grant      = w_idle && (r_pend_inrt || r_pend_a2d);
    assign w_pick_a2d   = r_pend_a2d && (!r_pend_inrt || (r_starve_cnt == MAX_WAIT_C));
    assign w_grant_inrt = w_grant && !w_pick_a2d;
    assign w_grant_a2d  = w_grant &&  w_pick_a2d;

    // A pulse is taken if the client has nothing pending, or if its pending
    // request is being granted in this very cycle (the holding register is
    // read by the grant before being overwritten on the same edge).
    assign w_accept_inrt = req_inrt && (!r_pend_inrt || w_grant_inrt);
    assign w_accept_a2d  = req_a2d  && (!r_pend_a2d  || w_grant_a2d);

    assign w_wd_expired  = (r_wd_cnt == TIMEOUT_C);

    // NOTE: combinational blocks give every output a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_grant) w_state_nxt = S_LAUNCH;
            S_LAUNCH:  w_state_nxt = S_WAIT;
            S_WAIT:    if (spi_done || w_wd_expired) w_state_nxt = S_RELEASE;
            S_RELEASE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!RST_n) begin
            r_state       <= S_IDLE;
            r_pend_inrt   <= 1'b0;
            r_pend_a2d    <= 1'b0;
            r_hold_inrt   <= '0;
            r_hold_a2d    <= '0;
            r_owner       <= 1'b0;
            r_wrt_data    <= '0;
            r_rdata_inrt  <= '0;
            r_rdata_a2d   <= '0;
            r_starve_cnt  <= '0;
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // Request latches: set on an accepted pulse, clear on grant.
            r_pend_inrt <= w_accept_inrt || (r_pend_inrt && !w_grant_inrt);
            r_pend_a2d  <= w_accept_a2d  || (r_pend_a2d  && !w_grant_a2d);
            if (w_accept_inrt) r_hold_inrt <= wdata_inrt;
            if (w_accept_a2d)  r_hold_a2d  <= wdata_a2d;

            if (w_grant) begin
                r_owner    <= w_pick_a2d;
                r_wrt_data <= w_pick_a2d ? r_hold_a2d : r_hold_inrt;
            end

            // Starvation guard: count inertial wins while the A2D waits.
            if (w_grant_a2d)
                r_starve_cnt <= '0;
            else if (w_grant_inrt && r_pend_a2d && (r_starve_cnt != MAX_WAIT_C))
                r_starve_cnt <= r_starve_cnt + 1'b1;

            // Watchdog restarts on every launch and runs only in WAIT.
            if (r_state == S_LAUNCH)
                r_wd_cnt <= '0;
            else if ((r_state == S_WAIT) && !w_wd_expired)
                r_wd_cnt <= r_wd_cnt + 1'b1;

            // A real completion wins over an expiry in the same cycle.
            if (r_state == S_WAIT) begin
                if (spi_done) begin
                    if (r_owner) r_rdata_a2d  <= spi_rd_data;
                    else         r_rdata_inrt <= spi_rd_data;
                end else if (w_wd_expired) begin
                    r_timeout_err <= 1'b1;
                    if (r_owner) r_rdata_a2d  <= 16'hFFFF;
                    else         r_rdata_inrt <= 16'hFFFF;
                end
            end
        end
    end

    // Outputs decoded from state; all return to reset values with the state.
    assign busy        = !w_idle;
    assign wrt         = (r_state == S_LAUNCH);
    assign wrt_data    = r_wrt_data;
    assign owner       = r_owner;
    assign done_inrt   = (r_state == S_RELEASE) && !r_owner;
    assign done_a2d    = (r_state == S_RELEASE) &&  r_owner;
    assign rdata_inrt  = r_rdata_inrt;
    assign rdata_a2d   = r_rdata_a2d;
    assign timeout_err = r_timeout_err;

    // Slave selects follow the master only for the owner of an active
    // transaction; the idle bus keeps both slaves deselected.
    assign SS_n_inrt = (busy && !r_owner) ? SS_n_mst : 1'b1;
    assign SS_n_a2d  = (busy &&  r_owner) ? SS_n_mst : 1'b1;
    assign MISO      = r_owner ? MISO_a2d : MISO_inrt;

endmodule

// File: doc/spi_bus_arb.md
# spi_bus_arb

Arbiter that shares the single SPI master between the inertial-sensor interface and the A2D interface (load cells, steering pot, battery). It latches one pending transaction per client, grants the bus with inertial priority and a starvation guard for the A2D, and launches the transfer on the master. It routes SS_n and MISO to the granted slave and returns the read data to the owning client. It sits between the two client interfaces and the SPI master inside the Segway digital core.

## Interface
- MAX_WAIT, 4: consecutive inertial grants allowed while an A2D request is pending; the next grant then goes to the A2D.
- TIMEOUT, 1048576: clocks in WAIT without spi_done before the transaction is aborted.
- clk  in  1  system clock; all logic is on its rising edge.
- RST_n  in  1  reset, synchronous, active-low.
- req_inrt  in  1  one-cycle request pulse from the inertial interface.
- wdata_inrt  in  16  command word; captured on the req_inrt cycle.
- done_inrt  out  1  one-cycle completion pulse.
- rdata_inrt  out  16  last read word for the inertial interface.
- req_a2d, wdata_a2d, done_a2d, rdata_a2d: same as the inertial set, for the A2D client.
- wrt  out  1  one-cycle launch pulse to the SPI master.
- wrt_data  out  16  command word to the master; held stable from LAUNCH through WAIT.
- spi_done  in  1  master completion pulse.
- spi_rd_data  in  16  master receive word; valid while spi_done is high.
- SS_n_mst  in  1  master slave-select.
- SS_n_inrt, SS_n_a2d  out  1  per-slave selects.
- MISO_inrt, MISO_a2d  in  1  slave data outputs.
- MISO  out  1  muxed data to the master.
- owner  out  1  current grant: 0 = inertial, 1 = A2D.
- busy  out  1  high when state is not IDLE.
- timeout_err  out  1  sticky; set by a watchdog abort.

## Operation
- Per-client pending flag and 16-bit holding register:
  - A req pulse sets the flag and loads the register.
  - A pulse while that client is already pending is dropped; the original word is kept.
  - A pulse while that client is being served sets a fresh pending request.
  - The flag clears when the client is granted.
- State machine IDLE -> LAUNCH -> WAIT -> RELEASE -> IDLE.
- IDLE, grant decision:
  - No pending flag: stay in IDLE.
  - Only one client pending: grant it.
  - Both pending: grant the inertial client unless starve_cnt == MAX_WAIT, in which case grant the A2D.
  - On a grant, latch owner, load wrt_data from the winner's holding register and go to LAUNCH.
- starve_cnt (saturating at MAX_WAIT):
  - Increments on each inertial grant while the A2D is pending.
  - Clears on each A2D grant.
- LAUNCH: wrt=1 for exactly this cycle, then WAIT.
- WAIT: watchdog counter runs.
  - On spi_done: capture spi_rd_data into the owner's rdata register and go to RELEASE.
  - If the counter reaches TIMEOUT first: set timeout_err, load the owner's rdata with 16'hFFFF and go to RELEASE.
- RELEASE: the owner's done pulses for one cycle, then IDLE.
- Routing:
  - SS_n_x = SS_n_mst while owner==x and busy; otherwise 1.
  - MISO = owner ? MISO_a2d : MISO_inrt.
- Ignored inputs: spi_done outside WAIT; SS_n_mst while IDLE.
- rdata_x holds its value until that client's next completion.

## Timing
- Reset values: wrt 0, wrt_data 0, done_* 0, rdata_* 0, SS_n_* 1, owner 0, busy 0, timeout_err 0. Pending flags, starve_cnt and watchdog clear; state IDLE.
- Reset mid-transaction aborts with no done pulse. SS_n_* are 1 in the cycle after RST_n is sampled low. The master shares the same reset.
- Idle-bus latency: req pulse in cycle 0 -> grant in cycle 1 (busy rises at the end of cycle 1) -> wrt=1 in cycle 2.
- Completion: spi_done in cycle k -> done_x and the new rdata_x in cycle k+1 -> IDLE in cycle k+2 -> the next wrt no earlier than cycle k+3.
- Simultaneous req pulses in one cycle: inertial is served first, A2D next, with no idle gap beyond IDLE and LAUNCH.
- A req pulse in the same cycle its done is high counts as a new request.
- Every request receives exactly one done pulse, including after a timeout.

## Test plan
- Single inertial request, wdata 16'h8F00; model the master to return 16'h0061 after 100 clocks -> wrt in cycle 2 with wrt_data 8F00; SS_n_inrt follows SS_n_mst; SS_n_a2d stays 1; done_inrt one cycle with rdata_inrt 0061.
- Both clients pulse in the same cycle (inertial 16'h2200, A2D 16'h0000) -> inertial transaction first, then A2D; each done fires once with its own rdata; no SS_n overlap.
- Inertial re-requests immediately after every done while the A2D stays pending, MAX_WAIT=4 -> exactly 4 inertial grants, then the A2D; starve_cnt returns to 0.
- Master never asserts spi_done, TIMEOUT=64 -> done_a2d 67 cycles after the grant, rdata_a2d FFFF, timeout_err stuck at 1 until reset.
- RST_n low during WAIT -> next cycle all outputs at reset values; a later request completes normally.
- Duplicate req_a2d pulse while pending, with a new wdata -> one transaction only, using the first wdata.
